// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among several byte sources.
// One byte per transaction: grant, strobe the write, then follow busy until the frame ends.
module uart_tx_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int START_TIMEOUT  = 4
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic [NUM_REQUESTERS-1:0]            req_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQUESTERS-1:0]            ack_o,
  output logic [NUM_REQUESTERS-1:0]            grant_o,
  output logic                                 tx_write_o,
  output logic [DATA_WIDTH-1:0]                tx_data_o,
  input  logic                                 tx_busy_i,
  output logic                                 active_o,
  output logic                                 timeout_o
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          last_grant;
  logic [CNT_W-1:0]          start_cnt;

  logic                      found;
  logic [IDX_W-1:0]          winner;
  logic [NUM_REQUESTERS-1:0] win_onehot;
  logic [DATA_WIDTH-1:0]     win_data;

  // Handshake: a requester holds req_i[k] and its byte stable until ack_o[k]
  // pulses; the arbiter only looks at req_i again once it is back in IDLE.
  // Two passes give ascending search from last_grant+1 with wrap-around:
  // first the indices above last_grant, then everything from 0.
  always_comb begin
    found      = 1'b0;
    winner     = last_grant;
    win_onehot = '0;
    win_data   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (!found && req_i[k] && (k > int'(last_grant))) begin
        found         = 1'b1;
        winner        = IDX_W'(k);
        win_onehot[k] = 1'b1;
        win_data      = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (!found && req_i[k]) begin
        found         = 1'b1;
        winner        = IDX_W'(k);
        win_onehot[k] = 1'b1;
        win_data      = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQUESTERS - 1);
      start_cnt  <= '0;
      ack_o      <= '0;
      grant_o    <= '0;
      tx_write_o <= 1'b0;
      tx_data_o  <= '0;
      active_o   <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      ack_o      <= '0;
      tx_write_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !tx_busy_i) begin
            state      <= ISSUE;
            tx_data_o  <= win_data;
            grant_o    <= win_onehot;
            ack_o      <= win_onehot;
            tx_write_o <= 1'b1;
            active_o   <= 1'b1;
            last_grant <= winner;
          end
        end
        ISSUE: begin
          state     <= WAIT_START;
          start_cnt <= '0;
        end
        WAIT_START: begin
          if (tx_busy_i) begin
            state <= WAIT_DONE;
          end else begin
            if (start_cnt != CNT_LIMIT) start_cnt <= start_cnt + CNT_W'(1);
            // The byte is dropped on timeout; the requester already got its ack.
            if (start_cnt >= CNT_LIMIT - CNT_W'(1)) begin
              timeout_o <= 1'b1;
              grant_o   <= '0;
              active_o  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            grant_o  <= '0;
            active_o <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: random byte queues per requester, a round-robin
// reference model feeding an expected queue, and a randomized transmitter.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data = '0;
  logic            tx_busy = 1'b0;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic            tx_write;
  logic [DW-1:0]   tx_data;
  logic            active;
  logic            timeout;

  uart_tx_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .req_i      (req),
    .data_i     (data),
    .ack_o      (ack),
    .grant_o    (grant),
    .tx_write_o (tx_write),
    .tx_data_o  (tx_data),
    .tx_busy_i  (tx_busy),
    .active_o   (active),
    .timeout_o  (timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [DW-1:0]    src_q [N][$];
  logic [IW+DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int model_last = N - 1;
  int exp_timeouts = 0;
  int seen_timeouts = 0;
  bit xmit_en = 1'b0;
  bit xmit_busy = 1'b0;
  bit gap_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: each write goes to the next non-empty source after the
  // previous winner, cycling through indices modulo N.
  task automatic build_expected();
    logic [DW-1:0] cp [N][$];
    int remaining = 0;
    for (int k = 0; k < N; k++) begin
      cp[k] = src_q[k];
      remaining += cp[k].size();
    end
    while (remaining > 0) begin
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (model_last + off) % N;
        if (cp[k].size() > 0) begin
          exp_q.push_back({IW'(k), cp[k].pop_front()});
          model_last = k;
          remaining--;
          break;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || active || tx_busy || xmit_busy || gap_pending) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_budget", 32'(n >= 3000), 0);
    repeat (3) @(negedge clk);
  endtask

  // requester driver: pop on ack, present the next byte at once
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (ack[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        req[k] = (src_q[k].size() != 0);
        if (src_q[k].size() != 0) data[k*DW +: DW] = src_q[k][0];
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [IW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (timeout) seen_timeouts++;
        check("grant_onehot", 32'($countones(grant) > 1), 0);
        if (tx_write) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%0h required=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[DW-1:0]));
            check("grant", 32'(grant), 32'(1) << e[IW+DW-1:DW]);
            check("ack", 32'(ack), 32'(1) << e[IW+DW-1:DW]);
            check("active", 32'(active), 1);
          end
        end else begin
          check("ack_quiet", 32'(ack), 0);
        end
      end
    end
  end

  // transmitter model: random start delay, frame length, or never starting
  initial begin
    int d, len, hb;
    forever begin
      @(negedge clk);
      if (gap_pending) begin
        gap_pending = 1'b0;
        check("reissue_gap", 32'(tx_write), 1);
      end
      if (xmit_en && !rst && tx_write) begin
        xmit_busy = 1'b1;
        if ($urandom_range(0, 4) == 0) begin
          for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("timeout_early", 32'(timeout), 0);
          end
          @(negedge clk);
          check("timeout_pulse", 32'(timeout), 1);
          check("timeout_idle", 32'(active), 0);
          check("timeout_grant", 32'(grant), 0);
          exp_timeouts++;
          hb = $urandom_range(0, 5);
          if (hb > 0) begin
            tx_busy = 1'b1;
            repeat (hb) begin
              @(negedge clk);
              check("write_while_busy", 32'(tx_write), 0);
            end
            tx_busy = 1'b0;
            gap_pending = (exp_q.size() != 0);
          end
        end else begin
          d = $urandom_range(0, TO);
          len = $urandom_range(2, 12);
          repeat (d) @(negedge clk);
          tx_busy = 1'b1;
          repeat (len) @(negedge clk);
          tx_busy = 1'b0;
          @(negedge clk);
          check("idle_grant", 32'(grant), 0);
          check("idle_active", 32'(active), 0);
          gap_pending = (exp_q.size() != 0);
        end
        xmit_busy = 1'b0;
      end
    end
  end

  // main sequence
  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_write", 32'(tx_write), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_active", 32'(active), 0);
    check("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    xmit_en = 1'b1;
    @(negedge clk);

    // single requester, byte 0x55
    src_q[0].push_back(8'h55);
    build_expected();
    wait_drain();

    // all four requesting, two rounds of 0xA0..0xA3
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) src_q[k].push_back(8'hA0 + 8'(k));
    build_expected();
    wait_drain();

    // random phases
    for (int p = 0; p < 30; p++) begin
      for (int k = 0; k < N; k++) begin
        cnt = $urandom_range(0, 4);
        for (int i = 0; i < cnt; i++) src_q[k].push_back(8'($urandom_range(0, 255)));
      end
      build_expected();
      wait_drain();
    end

    // reset during WAIT_DONE, then requester 0 must win first
    xmit_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_q[k].push_back(8'h10 + 8'(k));
      src_q[k].push_back(8'h20 + 8'(k));
    end
    build_expected();
    cnt = 0;
    while (!tx_write && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_test_write_seen", 32'(tx_write), 1);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_frame_active", 32'(active), 1);
    rst = 1'b1;
    tx_busy = 1'b0;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_write", 32'(tx_write), 0);
    check("mid_rst_data", 32'(tx_data), 0);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_timeout", 32'(timeout), 0);
    exp_q.delete();
    model_last = N - 1;
    build_expected();
    xmit_en = 1'b1;
    rst = 1'b0;
    wait_drain();

    check("timeout_count", 32'(seen_timeouts), 32'(exp_timeouts));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
